// File: rtl/ahb3lite_interconnect_slave_arbiter_pkg.sv
// Shared types for the AHB3-Lite multi-layer switch: per-slave arbiter
// state encoding and the master priority type.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_OWNED  = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_t;

  typedef logic [2:0] ahb_prio_t;

endpackage

// File: rtl/ahb3lite_interconnect_rr_select.sv
// Combinational winner selection: the highest priority requester wins, and
// ties go to the first requester found searching upward from rr_ptr+1.
module ahb3lite_interconnect_rr_select
  import ahb3lite_pkg::*;
#(
  parameter  int MASTERS  = 3,
  localparam int MST_BITS = $clog2(MASTERS)
) (
  input  logic [MASTERS-1:0]             req,
  input  ahb_prio_t [MASTERS-1:0]        prio,
  input  logic [MST_BITS-1:0]            rr_ptr,
  output logic [MST_BITS-1:0]            winner_idx,
  output logic                           winner_valid
);

  int        cand;
  ahb_prio_t best_prio;

  // Visiting candidates in round-robin order with a strict '>' lets the
  // earliest candidate in that order keep a tie.
  always_comb begin
    winner_idx   = '0;
    winner_valid = 1'b0;
    best_prio    = '0;
    cand         = 0;
    for (int k = 1; k <= MASTERS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= MASTERS) cand = cand - MASTERS;
      if (req[cand] && (!winner_valid || (prio[cand] > best_prio))) begin
        winner_valid = 1'b1;
        winner_idx   = MST_BITS'(cand);
        best_prio    = prio[cand];
      end
    end
  end

endmodule

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Per-slave arbiter of the AHB3-Lite multi-layer switch. It grants one master
// ownership of the slave and changes the grant only at legal transfer boundaries.
module ahb3lite_interconnect_slave_arbiter
  import ahb3lite_pkg::*;
#(
  parameter  int MASTERS  = 3,
  localparam int MST_BITS = $clog2(MASTERS)
) (
  input  logic                    HRESETn,
  input  logic                    HCLK,
  input  logic [MASTERS-1:0]      mst_req,
  input  ahb_prio_t [MASTERS-1:0] mst_priority,
  input  logic [MASTERS-1:0]      mst_can_switch,
  input  logic [MASTERS-1:0]      mst_HMASTLOCK,
  input  logic                    slv_HREADY,
  output logic [MASTERS-1:0]      mst_granted,
  output logic [MST_BITS-1:0]     granted_idx,
  output logic                    grant_valid
);

  arb_state_t          state_q, state_d;
  logic [MASTERS-1:0]  grant_q, grant_d;
  logic [MST_BITS-1:0] idx_q, idx_d;
  logic [MST_BITS-1:0] rr_ptr_q, rr_ptr_d;

  logic [MST_BITS-1:0] winner_idx;
  logic                winner_valid;
  logic                owner_req, owner_lock, owner_can_switch, switch_ok;

  ahb3lite_interconnect_rr_select #(.MASTERS(MASTERS)) u_select (
    .req          (mst_req),
    .prio         (mst_priority),
    .rr_ptr       (rr_ptr_q),
    .winner_idx   (winner_idx),
    .winner_valid (winner_valid)
  );

  assign owner_req        = mst_req[idx_q];
  assign owner_lock       = mst_HMASTLOCK[idx_q];
  assign owner_can_switch = mst_can_switch[idx_q];
  assign switch_ok        = slv_HREADY && !owner_lock && (owner_can_switch || !owner_req);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (winner_valid) begin
          state_d  = ARB_OWNED;
          grant_d  = MASTERS'(1) << winner_idx;
          idx_d    = winner_idx;
          rr_ptr_d = winner_idx;
        end
      end
      ARB_OWNED, ARB_LOCKED: begin
        if (state_q == ARB_OWNED && slv_HREADY && owner_req && owner_lock) begin
          state_d = ARB_LOCKED;
        end else if (state_q == ARB_OWNED || (slv_HREADY && !owner_lock)) begin
          state_d = ARB_OWNED;
          // A locked owner that releases is evaluated in the same cycle.
          if (switch_ok) begin
            if (!winner_valid) begin
              state_d = ARB_IDLE;
              grant_d = '0;
            end else if (winner_idx != idx_q) begin
              grant_d  = MASTERS'(1) << winner_idx;
              idx_d    = winner_idx;
              rr_ptr_d = winner_idx;
            end
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= MST_BITS'(MASTERS - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign mst_granted = grant_q;
  assign granted_idx = idx_q;
  assign grant_valid = |grant_q;

endmodule
